// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared constants and FSM state encodings for the program loader.
package program_loader_pkg;
    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = 6;
    localparam logic [2:0] S_LEN   = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams a length byte plus big-endian 16-bit words into program RAM,
// holding the CPU in reset until the load completes.
//   clk, reset_n (async, active-low)
//   rx_data/rx_valid/rx_ready : byte stream with valid/ready handshake
//   ram_we/ram_addr/ram_wdata : program RAM write port
//   cpu_reset_n               : released only after a successful load
//   load_done/load_error      : sticky status, cleared by reset
//   word_count                : words written so far
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader #(
    parameter int MEM_DEPTH = program_loader_pkg::MEM_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    output logic                                rx_ready,
    output logic                                ram_we,
    output logic [program_loader_pkg::ADDR_W-1:0] ram_addr,
    output logic [15:0]                         ram_wdata,
    output logic                                cpu_reset_n,
    output logic                                load_done,
    output logic                                load_error,
    output logic [6:0]                          word_count
);
    import program_loader_pkg::*;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_FIN = S_CSUM;
    logic [7:0] csum_q, csum_d;
`else
    localparam logic [2:0] S_FIN = S_DONE;
`endif
    logic [2:0]        state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [6:0]        wc_q, wc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              xfer;
    // Ready is a pure state decode, gated low while reset is held.
    assign rx_ready = reset_n && (state_q == S_LEN || state_q == S_HI || state_q == S_LO
`ifdef LOADER_CHECKSUM_EN
                      || state_q == S_CSUM
`endif
                      );
    assign xfer        = rx_valid && rx_ready;
    assign ram_we      = state_q == S_WRITE;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign cpu_reset_n = state_q == S_DONE;
    assign load_done   = state_q == S_DONE;
    assign load_error  = state_q == S_ERR;
    assign word_count  = wc_q;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        wc_d    = wc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (xfer && (state_q == S_HI || state_q == S_LO))
            csum_d = csum_q ^ rx_data;
`endif
        case (state_q)
            S_LEN: if (xfer) begin
                len_d   = rx_data;
                state_d = (rx_data != 8'd0 && int'(rx_data) <= MEM_DEPTH) ? S_HI : S_ERR;
            end
            S_HI: if (xfer) begin
                hi_d    = rx_data;
                state_d = S_LO;
            end
            // Address/data are latched here so the write strobe can be a pure state decode.
            S_LO: if (xfer) begin
                wdata_d = {hi_q, rx_data};
                addr_d  = wc_q[ADDR_W-1:0];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wc_d    = wc_q + 7'd1;
                state_d = ({1'b0, wc_q} + 8'd1 < len_q) ? S_HI : S_FIN;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_LEN;
            len_q   <= '0;
            hi_q    <= '0;
            wc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, meaning the number of 16-bit words in the target program RAM (6-bit address).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  incoming byte stream.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port ram_we  output  1  program RAM write strobe.
REQ-008 SHALL have port ram_addr  output  6  program RAM word address.
REQ-009 SHALL have port ram_wdata  output  16  program RAM write data.
REQ-010 SHALL have port cpu_reset_n  output  1  CPU hold-in-reset, low until the load completes.
REQ-011 SHALL have port load_done  output  1  load completed successfully (sticky).
REQ-012 SHALL have port load_error  output  1  load aborted (sticky).
REQ-013 SHALL have port word_count  output  7  words written so far.

Function
REQ-014 SHALL count a byte as transferred only in a cycle where rx_valid and rx_ready are both 1; rx_data is otherwise ignored.
REQ-015 SHALL implement the Moore FSM S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR; all outputs decode from registered state and registers only.
REQ-016 SHALL drive rx_ready=1 in S_LEN, S_HI, S_LO and S_CSUM, and rx_ready=0 in S_WRITE, S_DONE and S_ERR.
REQ-017 S_LEN: the transferred byte is the length N; if 1 <= N <= MEM_DEPTH, store N and go to S_HI; otherwise go to S_ERR.
REQ-018 S_HI: capture the byte as word bits [15:8] and go to S_LO; S_LO: capture the byte as bits [7:0] and go to S_WRITE.
REQ-019 S_WRITE SHALL last exactly one cycle with ram_we=1, ram_addr=index, ram_wdata={hi,lo}; index and word_count then increment by 1.
REQ-020 From S_WRITE, the FSM SHALL go to S_HI if the incremented word_count < N; otherwise go to S_CSUM (macro defined) or S_DONE (macro undefined).
REQ-021 The RAM write SHALL occur in the cycle immediately after the low byte transfer; minimum 3 cycles per word.
REQ-022 ram_we SHALL be 0 in every state other than S_WRITE; outside S_WRITE, ram_addr and ram_wdata hold their last values.
REQ-023 S_DONE: cpu_reset_n=1 and load_done=1, held until reset; further rx_valid is ignored.
REQ-024 S_ERR: cpu_reset_n=0 and load_error=1, held until reset.
REQ-025 Index SHALL never wrap: N = MEM_DEPTH writes addresses 0..63, then leaves the write loop.

Reset
REQ-026 Asserting reset_n low SHALL immediately force: state S_LEN, rx_ready=0 while reset is held, ram_we=0, ram_addr=0, ram_wdata=0, cpu_reset_n=0, load_done=0, load_error=0, word_count=0, checksum=0.
REQ-027 Reset asserted mid-load SHALL abandon the partial load; words already written stay in RAM, and the next load restarts at address 0 with a new length byte.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN: when defined, the loader SHALL keep an XOR of all data bytes (not the length byte); in S_CSUM, a transferred byte equal to that XOR goes to S_DONE, and any other value goes to S_ERR.
REQ-029 When LOADER_CHECKSUM_EN is undefined, S_CSUM and the checksum register SHALL not exist, and the FSM goes from the last S_WRITE directly to S_DONE.

Structure
REQ-030 State encodings (3-bit localparams) and MEM_DEPTH/ADDR_W constants SHALL live in shared package program_loader_pkg.
REQ-031 SHALL be a single module with no sub-module; it drives the program RAM's write port and the CPU's reset_n.

Verification
REQ-032 Send 0x02, 0x12, 0x34, 0xAB, 0xCD (checksum macro off) -> writes 0x1234@0 and 0xABCD@1; cpu_reset_n and load_done rise 1 cycle after the second write.
REQ-033 Same stream with macro on plus 0x40 (0x12^0x34^0xAB^0xCD) -> load_done=1; with 0x41 instead -> load_error=1 and cpu_reset_n stays 0.
REQ-034 Length 0x00 or 0x41 -> S_ERR with no ram_we pulse.
REQ-035 Length 0x40, 128 data bytes with rx_valid toggled randomly -> 64 writes to addresses 0..63, word_count=64, no write past 63.
REQ-036 Pull reset_n low after the first word of a 3-word load -> outputs reset asynchronously; a fresh 1-word load then writes address 0.
REQ-037 After load_done, drive rx_valid=1 with arbitrary bytes -> rx_ready=0, no ram_we pulse, and outputs unchanged.
